lsu_mem_adapter: RTL

Load/store adapter sitting directly upstream of the data memory stage. It accepts one load or store per request from the execute stage and issues word-aligned accesses to the memory block. Because the RAM has no byte enables, sub-word stores are done as read-modify-write. The block also performs load lane extraction, sign/zero extension, and misalignment/illegal-funct3 detection.

---
 rtl/lsu_mem_adapter_if.sv | 44 ++++
 rtl/lsu_mem_adapter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter_if.sv
// rtl/lsu_mem_adapter_if.sv - request/response/memory bus bundle for the load/store adapter
//
// Purpose: groups the execute-side request, the completion response and the
// word-wide data-memory port into one bundle.
// Ports (signals):
//    req_valid/req_ready/req_we/req_addr/req_wdata/req_funct3 : request from execute
//    resp_valid/resp_rdata/resp_err                           : one-cycle completion
//    mem_addr/mem_wren/mem_wr_data/mem_funct3/mem_rd_data     : word access to data RAM
// Modports: slave = adapter view, master = execute/memory environment view.

interface lsu_mem_adapter_if #(
   parameter int WIDTH = 32
);
   typedef logic [2:0] funct3_t;

   logic             req_valid;
   logic             req_ready;
   logic             req_we;
   logic [WIDTH-1:0] req_addr;
   logic [WIDTH-1:0] req_wdata;
   funct3_t          req_funct3;

   logic             resp_valid;
   logic [WIDTH-1:0] resp_rdata;
   logic             resp_err;

   logic [WIDTH-1:0] mem_addr;
   logic             mem_wren;
   logic [WIDTH-1:0] mem_wr_data;
   funct3_t          mem_funct3;
   logic [WIDTH-1:0] mem_rd_data;

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rd_data,
      output req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_wren, mem_wr_data, mem_funct3
   );

   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_funct3, mem_rd_data,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             mem_addr, mem_wren, mem_wr_data, mem_funct3
   );
endinterface

// File: rtl/lsu_mem_adapter.sv
// rtl/lsu_mem_adapter.sv - load/store adapter with sub-word read-modify-write
//
// Purpose: accepts one load or store at a time, issues word-aligned accesses to
// a RAM without byte enables (sub-word stores become read-modify-write),
// extracts and extends load lanes, and flags misaligned/illegal requests.
// Ports:
//    clk : rising-edge clock
//    rst : asynchronous active-low reset
//    bus : lsu_mem_adapter_if.slave (request, response, memory port)

module lsu_mem_adapter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   lsu_mem_adapter_if.slave bus
);
   if (WIDTH != 32) begin : g_width_check
      $error("lsu_mem_adapter: only WIDTH = 32 is supported");
   end

   typedef enum logic [2:0] {S_IDLE, S_READ, S_DATA, S_WRITE, S_RESP} state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   state_t           state_q, state_d;
   logic             we_q, we_d;
   logic [1:0]       lane_q, lane_d;       // byte offset within the word
   logic [2:0]       f3_q, f3_d;
   logic [15:0]      sdata_q, sdata_d;     // low store bits, only needed for sub-word merges
   logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
   logic [WIDTH-1:0] resp_rdata_q, resp_rdata_d;
   logic             resp_err_q, resp_err_d;

   logic             accept;
   logic             req_error;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [WIDTH-1:0] load_data;
   logic [WIDTH-1:0] merged;

   // Ready is gated by the reset pin itself so nothing is accepted while held in reset.
   assign bus.req_ready   = (state_q == S_IDLE) && rst;
   assign accept          = bus.req_valid && bus.req_ready;
   // Decoded from state only: an asynchronous reset kills a pending write immediately.
   assign bus.mem_wren    = (state_q == S_WRITE);
   assign bus.resp_valid  = (state_q == S_RESP);
   assign bus.mem_addr    = mem_addr_q;
   assign bus.mem_wr_data = mem_wr_data_q;
   assign bus.resp_rdata  = resp_rdata_q;
   assign bus.resp_err    = resp_err_q;
   assign bus.mem_funct3  = F3_W;

   always_comb begin
      req_error = 1'b0;
      if (bus.req_funct3 == 3'b011 || bus.req_funct3[2:1] == 2'b11)
         req_error = 1'b1;
      if (bus.req_we && bus.req_funct3[2])
         req_error = 1'b1;     // no unsigned stores
      if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0])
         req_error = 1'b1;
      if (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00)
         req_error = 1'b1;
   end

   // Lane extraction and store merge both work on the word read back in DATA.
   always_comb begin
      byte_sel = bus.mem_rd_data[{lane_q, 3'b000} +: 8];
      half_sel = bus.mem_rd_data[{lane_q[1], 4'b0000} +: 16];
      case (f3_q)
         F3_B:    load_data = {{(WIDTH-8){byte_sel[7]}}, byte_sel};
         F3_H:    load_data = {{(WIDTH-16){half_sel[15]}}, half_sel};
         F3_BU:   load_data = {{(WIDTH-8){1'b0}}, byte_sel};
         F3_HU:   load_data = {{(WIDTH-16){1'b0}}, half_sel};
         default: load_data = bus.mem_rd_data;
      endcase
      merged = bus.mem_rd_data;
      if (f3_q[0])
         merged[{lane_q[1], 4'b0000} +: 16] = sdata_q;
      else
         merged[{lane_q, 3'b000} +: 8] = sdata_q[7:0];
   end

   always_comb begin
      state_d       = state_q;
      we_d          = we_q;
      lane_d        = lane_q;
      f3_d          = f3_q;
      sdata_d       = sdata_q;
      mem_addr_d    = mem_addr_q;
      mem_wr_data_d = mem_wr_data_q;
      resp_rdata_d  = resp_rdata_q;
      resp_err_d    = resp_err_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               we_d         = bus.req_we;
               lane_d       = bus.req_addr[1:0];
               f3_d         = bus.req_funct3;
               sdata_d      = bus.req_wdata[15:0];
               resp_rdata_d = '0;
               resp_err_d   = req_error;
               if (req_error) begin
                  state_d = S_RESP;
               end else begin
                  mem_addr_d = {bus.req_addr[WIDTH-1:2], 2'b00};
                  if (bus.req_we && bus.req_funct3 == F3_W) begin
                     mem_wr_data_d = bus.req_wdata;
                     state_d       = S_WRITE;
                  end else begin
                     state_d = S_READ;
                  end
               end
            end
         end
         S_READ:  state_d = S_DATA;
         S_DATA: begin
            if (we_q) begin
               mem_wr_data_d = merged;
               state_d       = S_WRITE;
            end else begin
               resp_rdata_d = load_data;
               state_d      = S_RESP;
            end
         end
         S_WRITE: state_d = S_RESP;
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         we_q          <= 1'b0;
         lane_q        <= 2'b00;
         f3_q          <= 3'b000;
         sdata_q       <= '0;
         mem_addr_q    <= '0;
         mem_wr_data_q <= '0;
         resp_rdata_q  <= '0;
         resp_err_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         we_q          <= we_d;
         lane_q        <= lane_d;
         f3_q          <= f3_d;
         sdata_q       <= sdata_d;
         mem_addr_q    <= mem_addr_d;
         mem_wr_data_q <= mem_wr_data_d;
         resp_rdata_q  <= resp_rdata_d;
         resp_err_q    <= resp_err_d;
      end
   end
endmodule
